// File: rtl/ram_if_pkg.sv
// Shared MIG app-interface definitions for the DDR3 reader/writer pair.
package ram_if_pkg;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;
    localparam int         BURST_WORDS   = 8;

    typedef logic [127:0] burst_t;

    typedef enum logic [1:0] {
        FILL,
        DATA0,
        DATA1,
        CMD
    } wr_state_e;

    function automatic logic [BURST_WORDS-1:0] word_sel(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/ram_burst_buffer.sv
// 8x16 coalescing buffer for one BL=8 burst: words, valid bits, base, byte mask.
// Define RAM_WRITER_BYTE_MASK_EN to mask out words never written in this burst.
module ram_burst_buffer
    import ram_if_pkg::*;
#(
    parameter int ADDR_W = 27
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [15:0]            i_data,
    output logic [127:0]           o_data,
    output logic [BURST_WORDS-1:0] o_valid,
    output logic [ADDR_W-1:0]      o_base,
    output logic [7:0]             o_mask_hi,
    output logic [7:0]             o_mask_lo
);

    burst_t                 r_buf;
    logic [BURST_WORDS-1:0] r_valid;
    logic [ADDR_W-1:0]      r_base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf   <= '0;
            r_valid <= '0;
            r_base  <= '0;
        end else if (i_clear) begin
            r_buf   <= '0;
            r_valid <= '0;
        end else if (i_load) begin
            r_buf[{i_addr[2:0], 4'b0000} +: 16] <= i_data;
            r_valid <= r_valid | word_sel(i_addr[2:0]);
            r_base  <= {i_addr[ADDR_W-1:3], 3'b000};
        end
    end

    assign o_data  = r_buf;
    assign o_valid = r_valid;
    assign o_base  = r_base;

`ifdef RAM_WRITER_BYTE_MASK_EN
    // Upper beat carries words 4-7, lower beat words 0-3.
    always_comb begin
        o_mask_hi = '0;
        o_mask_lo = '0;
        for (int w = 0; w < 4; w++) begin
            o_mask_lo[2*w +: 2] = {2{~r_valid[w]}};
            o_mask_hi[2*w +: 2] = {2{~r_valid[w+4]}};
        end
    end
`else
    assign o_mask_hi = 8'h00;
    assign o_mask_lo = 8'h00;
`endif

endmodule

// File: rtl/ram_writer.sv
// Coalescing 16-bit word writer onto the DDR3 MIG app interface.
// Optional RAM_WRITER_BYTE_MASK_EN preserves unwritten words of partial bursts.
module ram_writer
    import ram_if_pkg::*;
#(
    parameter int ADDR_W            = 27,
    parameter int IDLE_FLUSH_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [15:0]       write_data,
    input  logic              write_valid,
    output logic              write_ready,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [2:0]        ram_cmd,
    output logic              ram_en,
    input  logic              ram_rdy,
    output logic [63:0]       ram_wdf_data,
    output logic              ram_wdf_wren,
    output logic              ram_wdf_end,
    output logic [7:0]        ram_wdf_mask,
    input  logic              ram_wdf_rdy
);

    localparam int IW = $clog2(IDLE_FLUSH_CYCLES + 2);

    wr_state_e r_state;
    logic      r_wren;
    logic      r_end;
    logic      r_en;
    logic [IW-1:0] r_idle;

    logic [127:0]           w_buf;
    logic [BURST_WORDS-1:0] w_valid;
    logic [BURST_WORDS-1:0] w_valid_next;
    logic [ADDR_W-1:0]      w_base;
    logic [7:0]             w_mask_hi;
    logic [7:0]             w_mask_lo;
    logic                   w_any_valid;
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_idle_hit;
    logic                   w_trigger;
    logic                   w_flush_go;

    ram_burst_buffer #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_clear   (w_clear),
        .i_addr    (write_address),
        .i_data    (write_data),
        .o_data    (w_buf),
        .o_valid   (w_valid),
        .o_base    (w_base),
        .o_mask_hi (w_mask_hi),
        .o_mask_lo (w_mask_lo)
    );

    assign w_any_valid = |w_valid;
    assign write_ready = (r_state == FILL) &&
                         (!w_any_valid ||
                          write_address[ADDR_W-1:3] == w_base[ADDR_W-1:3]);
    assign w_accept    = write_valid && write_ready;
    assign w_clear     = (r_state == CMD) && ram_rdy;

    assign w_valid_next = w_valid |
                          (w_accept ? word_sel(write_address[2:0]) : '0);

    // r_idle counts cycles since the last accept, the accept cycle included.
    assign w_idle_hit = (IDLE_FLUSH_CYCLES != 0) && !w_accept &&
                        (int'(r_idle) + 1 >= IDLE_FLUSH_CYCLES);

    assign w_trigger  = (&w_valid_next) ||
                        (write_valid && !write_ready) ||
                        flush || w_idle_hit;
    assign w_flush_go = (r_state == FILL) && (|w_valid_next) && w_trigger;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle <= '0;
        end else if (w_clear) begin
            r_idle <= '0;
        end else if (w_accept) begin
            r_idle <= IW'(1);
        end else if (r_state == FILL && w_any_valid && r_idle != '1) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL;
            r_wren  <= 1'b0;
            r_end   <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_flush_go) begin
                        r_state <= DATA0;
                        r_wren  <= 1'b1;
                        r_end   <= 1'b0;
                    end
                end
                DATA0: begin
                    if (ram_wdf_rdy) begin
                        r_state <= DATA1;
                        r_end   <= 1'b1;
                    end
                end
                DATA1: begin
                    if (ram_wdf_rdy) begin
                        r_state <= CMD;
                        r_wren  <= 1'b0;
                        r_end   <= 1'b0;
                        r_en    <= 1'b1;
                    end
                end
                CMD: begin
                    if (ram_rdy) begin
                        r_state <= FILL;
                        r_en    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Non-end beat carries the upper words, matching the read path.
    always_comb begin
        ram_wdf_data = 64'h0;
        ram_wdf_mask = 8'h00;
        if (r_state == DATA0) begin
            ram_wdf_data = w_buf[127:64];
            ram_wdf_mask = w_mask_hi;
        end else if (r_state == DATA1) begin
            ram_wdf_data = w_buf[63:0];
            ram_wdf_mask = w_mask_lo;
        end
    end

    assign ram_wdf_wren = r_wren;
    assign ram_wdf_end  = r_end;
    assign ram_en       = r_en;
    assign ram_cmd      = MIG_CMD_WRITE;
    assign ram_address  = (r_state == CMD) ? w_base : '0;
    assign busy         = (r_state != FILL) || w_any_valid;

endmodule
